// File: rtl/cmd_pkg.sv
// Shared command-interface types: byte type, response opcodes, payload limit
// and the response-transmitter state encoding (CHECKSUM only with CMD_RSP_TX_CHECKSUM_EN).
package cmd_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [7:0] {
    RSP_ACK    = 8'h80,
    RSP_NACK   = 8'h81,
    RSP_STATUS = 8'h82
  } rsp_opcode_t;

  localparam int CMD_RSP_MAX_PAYLOAD = 8;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_OPCODE,
    TX_LENGTH,
    TX_PAYLOAD
`ifdef CMD_RSP_TX_CHECKSUM_EN
    ,
    TX_CHECKSUM
`endif
  } cmd_rsp_tx_state_t;

endpackage

// File: rtl/cmd_rsp_tx.sv
// Response transmitter: serialises opcode, length and payload onto the cmd_out byte stream.
// Define CMD_RSP_TX_CHECKSUM_EN to append an XOR checksum byte to every frame.
module cmd_rsp_tx
  import cmd_pkg::*;
#(
  parameter int MAX_PAYLOAD = CMD_RSP_MAX_PAYLOAD,
  parameter int LEN_W       = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     rsp_valid,
  output logic                     rsp_ready,
  input  logic [7:0]               rsp_opcode,
  input  logic [LEN_W-1:0]         rsp_length,
  input  logic [8*MAX_PAYLOAD-1:0] rsp_payload,
  output logic                     cmd_out_valid,
  input  logic                     cmd_out_ready,
  output byte_t                    cmd_out_data,
  output logic                     busy,
  output logic [15:0]              frames_sent
);

  // Handshakes on both sides are plain valid/ready: a transfer happens on a
  // rising clk where valid && ready; once cmd_out_valid is high it and
  // cmd_out_data hold until that transfer, and valid never looks at ready.

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PAYLOAD);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  cmd_rsp_tx_state_t        state;
  logic [LEN_W-1:0]         len_q;
  logic [LEN_W-1:0]         idx;
  logic [8*MAX_PAYLOAD-1:0] payload_q;
  logic [8*MAX_PAYLOAD-1:0] payload_shift;
  logic [LEN_W-1:0]         len_clamped;
  logic                     hs;
  logic                     data_done;
  logic                     frame_done;
`ifdef CMD_RSP_TX_CHECKSUM_EN
  byte_t                    csum;
`endif

  assign len_clamped   = (rsp_length > MAX_LEN) ? MAX_LEN : rsp_length;
  assign hs            = cmd_out_valid && cmd_out_ready;
  assign payload_shift = payload_q >> 8;
  assign busy          = (state != TX_IDLE);

  // data_done marks the handshake of the last opcode/length/payload byte.
  assign data_done = hs && (((state == TX_LENGTH) && (len_q == '0)) ||
                            ((state == TX_PAYLOAD) && (idx == len_q - ONE)));
`ifdef CMD_RSP_TX_CHECKSUM_EN
  assign frame_done = hs && (state == TX_CHECKSUM);
`else
  assign frame_done = data_done;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= TX_IDLE;
      rsp_ready     <= 1'b1;
      cmd_out_valid <= 1'b0;
      cmd_out_data  <= '0;
      frames_sent   <= '0;
      len_q         <= '0;
      idx           <= '0;
      payload_q     <= '0;
`ifdef CMD_RSP_TX_CHECKSUM_EN
      csum          <= '0;
`endif
    end else begin
      unique case (state)
        TX_IDLE: begin
          if (rsp_valid && rsp_ready) begin
            state         <= TX_OPCODE;
            rsp_ready     <= 1'b0;
            cmd_out_valid <= 1'b1;
            cmd_out_data  <= rsp_opcode;
            len_q         <= len_clamped;
            payload_q     <= rsp_payload;
            idx           <= '0;
          end
        end
        TX_OPCODE: begin
          if (hs) begin
            state        <= TX_LENGTH;
            cmd_out_data <= byte_t'(len_q);
          end
        end
        TX_LENGTH: begin
          if (hs && (len_q != '0)) begin
            state        <= TX_PAYLOAD;
            cmd_out_data <= payload_q[7:0];
          end
        end
        TX_PAYLOAD: begin
          // Payload is shifted down so the next byte is always at the bottom.
          if (hs && (idx != len_q - ONE)) begin
            idx          <= idx + ONE;
            payload_q    <= payload_shift;
            cmd_out_data <= payload_shift[7:0];
          end
        end
`ifdef CMD_RSP_TX_CHECKSUM_EN
        TX_CHECKSUM: ;
`endif
        default: state <= TX_IDLE;
      endcase

`ifdef CMD_RSP_TX_CHECKSUM_EN
      if (rsp_valid && rsp_ready)
        csum <= '0;
      else if (hs)
        csum <= csum ^ cmd_out_data;

      if (data_done) begin
        state        <= TX_CHECKSUM;
        cmd_out_data <= csum ^ cmd_out_data;
      end
`endif

      if (frame_done) begin
        state         <= TX_IDLE;
        cmd_out_valid <= 1'b0;
        rsp_ready     <= 1'b1;
        frames_sent   <= frames_sent + 16'd1;
      end
    end
  end

endmodule
